// File: rtl/cte_pkg.sv
// Shared constants, types and helpers for the CTE RGB-to-YUV 4:2:2 encoder.
// Coefficients are scaled by 2^8; accumulation is 18-bit signed.
package cte_pkg;

  localparam int CTE_COEF_FRAC = 8;
  localparam int ACC_W         = 18;
  localparam int CH_W          = 8;
  localparam int PIX_W         = 3 * CH_W;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t Y_R =  18'sd77;
  localparam acc_t Y_G =  18'sd150;
  localparam acc_t Y_B =  18'sd29;
  localparam acc_t U_R = -18'sd43;
  localparam acc_t U_G = -18'sd85;
  localparam acc_t U_B =  18'sd128;
  localparam acc_t V_R =  18'sd128;
  localparam acc_t V_G = -18'sd107;
  localparam acc_t V_B = -18'sd21;

  localparam acc_t Y_MIN  =  18'sd0;
  localparam acc_t Y_MAX  =  18'sd255;
  localparam acc_t UV_MIN = -18'sd128;
  localparam acc_t UV_MAX =  18'sd127;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    CALC0,
    CALC1,
    EMIT_U,
    EMIT_Y0,
    EMIT_V,
    EMIT_Y1
  } cte_state_e;

  typedef struct packed {
    logic [CH_W-1:0] y;
    logic [CH_W-1:0] u;
    logic [CH_W-1:0] v;
  } yuv_t;

  // Zero-extend one unsigned colour channel into the signed accumulator domain.
  function automatic acc_t chan(input logic [PIX_W-1:0] rgb, input int lsb);
    return $signed({{(ACC_W-CH_W){1'b0}}, rgb[lsb +: CH_W]});
  endfunction

  function automatic logic [CH_W-1:0] clamp8(input acc_t x, input acc_t lo, input acc_t hi);
    acc_t c;
    c = (x < lo) ? lo : ((x > hi) ? hi : x);
    return c[CH_W-1:0];
  endfunction

endpackage

// File: rtl/cte_yuv_calc.sv
// Combinational RGB -> clamped Y/U/V for a single pixel.
// Rounds half-up then floors via arithmetic shift; U/V leave as two's complement.
module cte_yuv_calc
  import cte_pkg::*;
#(
  parameter int COEF_FRAC = CTE_COEF_FRAC
) (
  input  logic [PIX_W-1:0] rgb,
  output yuv_t             yuv
);

  localparam acc_t RND = acc_t'(1) <<< (COEF_FRAC - 1);

  acc_t r, g, b;
  acc_t y_acc, u_acc, v_acc;

  always_comb begin
    r     = chan(rgb, R_LSB);
    g     = chan(rgb, G_LSB);
    b     = chan(rgb, B_LSB);
    y_acc = (Y_R * r + Y_G * g + Y_B * b + RND) >>> COEF_FRAC;
    u_acc = (U_R * r + U_G * g + U_B * b + RND) >>> COEF_FRAC;
    v_acc = (V_R * r + V_G * g + V_B * b + RND) >>> COEF_FRAC;
    yuv.y = clamp8(y_acc, Y_MIN, Y_MAX);
    yuv.u = clamp8(u_acc, UV_MIN, UV_MAX);
    yuv.v = clamp8(v_acc, UV_MIN, UV_MAX);
  end

endmodule

// File: rtl/cte_rgb2yuv.sv
// RGB pixel FIFO feeding a pair-at-a-time 4:2:2 packer.
// Byte order per pair: U0, Y0, V0, Y1 (chroma from the even pixel).
module cte_rgb2yuv
  import cte_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int COEF_FRAC  = CTE_COEF_FRAC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_en,
  input  logic [PIX_W-1:0] rgb_in,
  output logic             busy,
  output logic             out_valid,
  output logic [CH_W-1:0]  yuv_out
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [PIX_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, pair_rdy;

  cte_state_e      state;
  logic [CH_W-1:0] y0_q, u_q, v_q, y1_q;
  logic [PIX_W-1:0] head;
  yuv_t             calc;

  // busy comes from the registered count, so a same-cycle pop never frees a slot early.
  assign busy     = (count == CW'(FIFO_DEPTH));
  assign push     = in_en && !busy;
  assign pop      = (state == CALC0) || (state == CALC1);
  assign pair_rdy = (count >= CW'(2));
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rgb_in;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  cte_yuv_calc #(.COEF_FRAC(COEF_FRAC)) u_calc (
    .rgb (head),
    .yuv (calc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      y0_q  <= '0;
      u_q   <= '0;
      v_q   <= '0;
      y1_q  <= '0;
    end else begin
      case (state)
        IDLE:    if (pair_rdy) state <= CALC0;
        CALC0: begin
          y0_q  <= calc.y;
          u_q   <= calc.u;
          v_q   <= calc.v;
          state <= CALC1;
        end
        CALC1: begin
          y1_q  <= calc.y;
          state <= EMIT_U;
        end
        EMIT_U:  state <= EMIT_Y0;
        EMIT_Y0: state <= EMIT_V;
        EMIT_V:  state <= EMIT_Y1;
        EMIT_Y1: state <= pair_rdy ? CALC0 : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output is a pure decode of state + result regs so reset silences it at once.
  always_comb begin
    out_valid = 1'b0;
    yuv_out   = '0;
    case (state)
      EMIT_U:  begin out_valid = 1'b1; yuv_out = u_q;  end
      EMIT_Y0: begin out_valid = 1'b1; yuv_out = y0_q; end
      EMIT_V:  begin out_valid = 1'b1; yuv_out = v_q;  end
      EMIT_Y1: begin out_valid = 1'b1; yuv_out = y1_q; end
      default: begin out_valid = 1'b0; yuv_out = '0;   end
    endcase
  end

endmodule

// File: doc/cte_rgb2yuv.md
Name: cte_rgb2yuv

Overview:
RGB-to-YUV 4:2:2 encoder, the reverse direction of the CTE YUV-to-RGB path.
- Accepts 24-bit RGB pixels under a busy/in_en handshake.
- Emits a serial 8-bit YUV byte stream in the order U0, Y0, V0, Y1 for each pixel pair. U and V are taken from the even pixel.
- Feeds the CTE byte-stream consumer and the golden-file benches; one byte out per out_valid pulse.

Parameters:
- FIFO_DEPTH, 4: pixel input buffer depth; power of two, ≥2.
- COEF_FRAC, 8: fractional bits of the fixed-point coefficients.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_en  input  1  pixel valid; accepted on a rising edge when busy=0.
- rgb_in  input  24  pixel; R=[23:16], G=[15:8], B=[7:0], all unsigned.
- busy  output  1  high when the pixel FIFO is full; input is refused.
- out_valid  output  1  yuv_out carries a valid byte this cycle.
- yuv_out  output  8  Y unsigned 0..255; U and V two's-complement -128..127.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers/count cleared; FSM to IDLE; result registers cleared.
  - busy=0, out_valid=0, yuv_out=8'h00.
  - Reset mid-emit discards any partial pair and all buffered pixels.
- Input FIFO:
  - Push when in_en && !busy. busy = (count==FIFO_DEPTH), decoded from the registered count.
  - in_en while busy is ignored; the pixel is not stored.
  - Simultaneous push and pop leaves count unchanged. A pop while full does not unblock a push in that same cycle.
- Arithmetic (per pixel, combinational, then registered):
  - Y = 77R + 150G + 29B
  - U = -43R - 85G + 128B
  - V = 128R - 107G - 21B
  - Use 18-bit signed accumulation.
  - Add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC (floor).
  - Clamp Y to 0..255; clamp U and V to -128..127.
- FSM states: IDLE, CALC0, CALC1, EMIT_U, EMIT_Y0, EMIT_V, EMIT_Y1.
  - IDLE → CALC0 when count≥2 (a complete pair is buffered).
  - CALC0: pop even pixel; register Y0, U, V. Next state CALC1.
  - CALC1: pop odd pixel; register Y1. Next state EMIT_U.
  - EMIT_*: out_valid=1; yuv_out = the corresponding register; one byte per cycle.
  - EMIT_Y1 → CALC0 if count≥2, else IDLE.
  - out_valid and yuv_out are decoded from the state and result registers only. yuv_out=00 when out_valid=0.
- Latency and throughput:
  - If the odd pixel is captured at edge t, U0 is valid after edge t+3. Y1 is valid after edge t+6.
  - Sustained rate is 6 cycles per pair.
- Odd pixel count: a lone even pixel stays in the FIFO until its partner arrives. There is no flush; output is never truncated mid-pair.

Decomposition:
- Package cte_pkg holds:
  - coefficient localparams: Y_R/G/B, U_R/G/B, V_R/G/B;
  - COEF_FRAC default;
  - clamp limits;
  - the FSM state enum;
  - the RGB field slice positions.
- Sub-module cte_yuv_calc: purely combinational. Takes a 24-bit RGB pixel and returns clamped Y, U, V (8 bits each). It is instantiated once, and its inputs are muxed from the FIFO head.

Test Plan:
- Pair 000000, FFFFFF → bytes 00,00,00,FF; out_valid high exactly 4 cycles; U0 valid 3 edges after the second pixel is captured.
- Pair FF0000, FF0000 → D5,4D,7F,4D (V clamped from 128 to 127).
- Pair 0000FF, 00FF00 → 7F,1D,EB,95. Check green alone: Y=95, U=AB, V=95.
- Back-to-back 9 pixels, in_en held high, FIFO_DEPTH=4:
  - busy asserts; no pixel is lost or duplicated;
  - exactly 16 bytes emitted for the first 8 pixels;
  - the 9th pixel is held, with no output, until a 10th pixel is driven.
- Reset asserted during EMIT_V → out_valid and yuv_out go to 0 immediately (asynchronously). After release, a fresh pair produces a correct 4-byte group with no stale bytes.
- Random 500-pixel stream with random in_en gaps → byte stream matches the reference model's golden file; count is 1000 bytes.
